// File: rtl/seg7_vga_pkg.sv
// seg7_vga_pkg: shared types and constants for the seven-segment VGA overlay.
//   state_e     - countdown state machine states (COUNT, BLINK)
//   SEG_*       - bit positions of each segment inside an 8-bit digit mask
//   CYAN, BLACK - 6-bit RRGGBB colours used by the renderer
//   bcd_to_seg  - 10-entry BCD digit to segment pattern table (dp not included)
package seg7_vga_pkg;

    typedef enum logic [0:0] {
        COUNT = 1'b0,
        BLINK = 1'b1
    } state_e;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [5:0] CYAN  = 6'b001111;
    localparam logic [5:0] BLACK = 6'b000000;

    // Bit 0 = a ... bit 6 = g. Codes above 9 never occur and render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'h3f;
            4'd1:    segs = 7'h06;
            4'd2:    segs = 7'h5b;
            4'd3:    segs = 7'h4f;
            4'd4:    segs = 7'h66;
            4'd5:    segs = 7'h6d;
            4'd6:    segs = 7'h7d;
            4'd7:    segs = 7'h07;
            4'd8:    segs = 7'h7f;
            4'd9:    segs = 7'h6f;
            default: segs = 7'h00;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/seg7_vga_overlay_glyph.sv
// seg7_glyph: combinational hit test of one seven-segment digit cell.
//   dx, dy - signed pixel offset from the cell's top-left corner
//   mask   - enabled segments, bit0 = a ... bit6 = g, bit7 = dp
//   hit    - pixel lies in an enabled segment
// Build option SEG7_BEVEL_EN: mitre the ends of segments a..g (dp stays square).
module seg7_glyph
    import seg7_vga_pkg::*;
#(
    parameter int SEG_LEN = 32,
    parameter int SEG_W   = 8
) (
    input  logic signed [10:0] dx,
    input  logic signed [10:0] dy,
    input  logic [7:0]         mask,
    output logic               hit
);

    localparam int W    = SEG_LEN + 2 * SEG_W;
    localparam int H    = 2 * SEG_LEN + 3 * SEG_W;
    localparam int LowY = SEG_LEN + 2 * SEG_W;

    function automatic logic in_rng(input logic signed [10:0] p, input int lo, input int hi);
        return (int'(p) >= lo) && (int'(p) < hi);
    endfunction

    logic [7:0] rect;
    logic [6:0] shape;

    always_comb begin
        rect         = '0;
        rect[SEG_A]  = in_rng(dx, SEG_W, SEG_W + SEG_LEN) && in_rng(dy, 0, SEG_W);
        rect[SEG_G]  = in_rng(dx, SEG_W, SEG_W + SEG_LEN) &&
                       in_rng(dy, SEG_LEN + SEG_W, SEG_LEN + 2 * SEG_W);
        rect[SEG_D]  = in_rng(dx, SEG_W, SEG_W + SEG_LEN) && in_rng(dy, H - SEG_W, H);
        rect[SEG_F]  = in_rng(dx, 0, SEG_W) && in_rng(dy, SEG_W, SEG_W + SEG_LEN);
        rect[SEG_E]  = in_rng(dx, 0, SEG_W) && in_rng(dy, LowY, LowY + SEG_LEN);
        rect[SEG_B]  = in_rng(dx, W - SEG_W, W) && in_rng(dy, SEG_W, SEG_W + SEG_LEN);
        rect[SEG_C]  = in_rng(dx, W - SEG_W, W) && in_rng(dy, LowY, LowY + SEG_LEN);
        rect[SEG_DP] = in_rng(dx, W + 2, W + 2 + SEG_W) && in_rng(dy, H - SEG_W, H);
    end

`ifdef SEG7_BEVEL_EN
    // u runs along the segment, v across it; keep pixels inside the two 45-degree mitres.
    function automatic logic bevel_ok(input int u, input int v);
        int a;
        a = (v >= SEG_W / 2) ? (v - SEG_W / 2) : (SEG_W / 2 - v);
        return (u >= a) && ((SEG_LEN - 1 - u) >= a);
    endfunction

    always_comb begin
        shape        = '0;
        shape[SEG_A] = rect[SEG_A] && bevel_ok(int'(dx) - SEG_W, int'(dy));
        shape[SEG_G] = rect[SEG_G] && bevel_ok(int'(dx) - SEG_W, int'(dy) - (SEG_LEN + SEG_W));
        shape[SEG_D] = rect[SEG_D] && bevel_ok(int'(dx) - SEG_W, int'(dy) - (H - SEG_W));
        shape[SEG_F] = rect[SEG_F] && bevel_ok(int'(dy) - SEG_W, int'(dx));
        shape[SEG_E] = rect[SEG_E] && bevel_ok(int'(dy) - LowY, int'(dx));
        shape[SEG_B] = rect[SEG_B] && bevel_ok(int'(dy) - SEG_W, int'(dx) - (W - SEG_W));
        shape[SEG_C] = rect[SEG_C] && bevel_ok(int'(dy) - LowY, int'(dx) - (W - SEG_W));
    end
`else
    assign shape = rect[6:0];
`endif

    assign hit = |({rect[SEG_DP], shape} & mask);

endmodule

// File: rtl/seg7_vga_overlay.sv
// seg7_vga_overlay: draws DIGITS seven-segment digits (with dp) over a VGA background.
// A frame-rate state machine runs a looping BCD countdown followed by a dp blink phase;
// a non-zero user_seg seen on frame_tick switches permanently (until reset) to user mode.
//   clk, rst_n            - pixel clock, synchronous active-low reset
//   hpos, vpos            - pixel position; display_on - visible area flag
//   hsync_in, vsync_in    - syncs aligned with hpos; bg_rgb - background pixel
//   frame_tick            - one pulse per frame during vertical blank
//   user_seg              - byte i drives digit i (bit0 = a ... bit7 = dp)
//   rgb                   - output pixel, 2 cycles after its inputs
//   hsync_out, vsync_out  - syncs delayed 2 cycles; show - sticky user-mode flag
// Build option SEG7_BEVEL_EN (in seg7_glyph): mitred segment ends, same latency.
module seg7_vga_overlay
    import seg7_vga_pkg::*;
#(
    parameter int DIGITS          = 2,
    parameter int SEG_LEN         = 32,
    parameter int SEG_W           = 8,
    parameter int ORIGIN_X        = 192,
    parameter int ORIGIN_Y        = 160,
    parameter int DIGIT_PITCH     = 64,
    parameter int FRAMES_PER_STEP = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  display_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [5:0]            bg_rgb,
    input  logic                  frame_tick,
    input  logic [8*DIGITS-1:0]   user_seg,
    output logic [5:0]            rgb,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  show
);

    localparam int W     = SEG_LEN + 2 * SEG_W;
    localparam int H     = 2 * SEG_LEN + 3 * SEG_W;
    localparam int CellW = W + 2 + SEG_W;  // includes the dp column
    localparam int FcW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [FcW-1:0]      FcLast   = FcW'(FRAMES_PER_STEP - 1);
    localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

    // ---------------------------------------------------------------- animation state
    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [2:0]          blink_q, blink_d;
    logic [FcW-1:0]      fcnt_q, fcnt_d;
    logic [8*DIGITS-1:0] shadow_q;
    logic                step;

    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Uses the current show, so a step coinciding with show rising still completes.
    assign step = frame_tick && !show && (fcnt_q == FcLast);

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        blink_d = blink_q;
        fcnt_d  = fcnt_q;
        if (frame_tick && !show) begin
            fcnt_d = step ? '0 : fcnt_q + 1'b1;
        end
        if (step) begin
            case (state_q)
                COUNT: begin
                    if (bcd_q == '0) begin
                        state_d = BLINK;
                        blink_d = '0;
                    end else begin
                        bcd_d = bcd_dec(bcd_q);
                    end
                end
                BLINK: begin
                    if (blink_q == 3'd5) begin
                        state_d = COUNT;
                        bcd_d   = AllNines;
                        blink_d = '0;
                    end else begin
                        blink_d = blink_q + 3'd1;
                    end
                end
                default: state_d = COUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= COUNT;
            bcd_q    <= AllNines;
            blink_q  <= '0;
            fcnt_q   <= '0;
            shadow_q <= '0;
            show     <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            blink_q <= blink_d;
            fcnt_q  <= fcnt_d;
            if (frame_tick) begin
                shadow_q <= user_seg;
                show     <= show | (|user_seg);
            end
        end
    end

    // ---------------------------------------------------------------- pixel pipeline
    logic             disp_q, hs_q, vs_q;
    logic [5:0]       bg_q;
    logic [DIGITS-1:0] digit_hit;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam int CellX = ORIGIN_X + (DIGITS - 1 - i) * DIGIT_PITCH;

        logic signed [10:0] dx_c, dy_c, dx_q, dy_q;
        logic               in_cell_c, in_cell_q, seg_hit;
        logic [7:0]         fsm_mask, mask;

        assign dx_c      = $signed({1'b0, hpos}) - 11'(CellX);
        assign dy_c      = $signed({1'b0, vpos}) - 11'(ORIGIN_Y);
        assign in_cell_c = (int'(dx_c) >= 0) && (int'(dx_c) < CellW) &&
                           (int'(dy_c) >= 0) && (int'(dy_c) < H);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dx_q      <= '0;
                dy_q      <= '0;
                in_cell_q <= 1'b0;
            end else begin
                dx_q      <= dx_c;
                dy_q      <= dy_c;
                in_cell_q <= in_cell_c;
            end
        end

        // Masks only change on frame_tick (vertical blank), so no tearing mid-frame.
        assign fsm_mask = (state_q == COUNT) ? {1'b0, bcd_to_seg(bcd_q[4*i +: 4])}
                                             : {~blink_q[0], 7'b0};
        assign mask     = show ? shadow_q[8*i +: 8] : fsm_mask;

        seg7_glyph #(
            .SEG_LEN (SEG_LEN),
            .SEG_W   (SEG_W)
        ) u_glyph (
            .dx   (dx_q),
            .dy   (dy_q),
            .mask (mask),
            .hit  (seg_hit)
        );

        assign digit_hit[i] = in_cell_q && seg_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            bg_q      <= '0;
            rgb       <= BLACK;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            disp_q    <= display_on;
            hs_q      <= hsync_in;
            vs_q      <= vsync_in;
            bg_q      <= bg_rgb;
            hsync_out <= hs_q;
            vsync_out <= vs_q;
            if (!disp_q) begin
                rgb <= BLACK;
            end else if (|digit_hit) begin
                rgb <= CYAN;
            end else begin
                rgb <= bg_q;
            end
        end
    end

endmodule

// File: tb/tb_seg7_vga_overlay.sv
// Self-checking bench for seg7_vga_overlay (DIGITS=2, FRAMES_PER_STEP=4) against a
// behavioural model: integer countdown value, blink phase index and rectangle geometry.
module tb_seg7_vga_overlay;

    localparam int DIGITS = 2;
    localparam int SL     = 32;
    localparam int SW     = 8;
    localparam int OX     = 192;
    localparam int OY     = 160;
    localparam int PITCH  = 64;
    localparam int FPS    = 4;
    localparam int W      = SL + 2 * SW;
    localparam int H      = 2 * SL + 3 * SW;
    localparam int MAXV   = 99;
    localparam logic [5:0] CYAN_C = 6'b001111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  hpos = '0, vpos = '0;
    logic        display_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, frame_tick = 1'b0;
    logic [5:0]  bg_rgb = '0;
    logic [15:0] user_seg = '0;
    logic [5:0]  rgb;
    logic        hsync_out, vsync_out, show;

    int tests_run = 0;
    int tests_failed = 0;

    // model state
    int          m_value = MAXV;
    int          m_blink = -1;  // -1 while counting, else blink phase index
    int          m_frames = 0;
    bit          m_show = 0;
    logic [15:0] m_shadow = '0;

    seg7_vga_overlay #(
        .DIGITS          (DIGITS),
        .SEG_LEN         (SL),
        .SEG_W           (SW),
        .ORIGIN_X        (OX),
        .ORIGIN_Y        (OY),
        .DIGIT_PITCH     (PITCH),
        .FRAMES_PER_STEP (FPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .bg_rgb     (bg_rgb),
        .frame_tick (frame_tick),
        .user_seg   (user_seg),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .show       (show)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic logic [6:0] digit_segs(input int n);
        case (n)
            0: return 7'b0111111;  // a b c d e f
            1: return 7'b0000110;  // b c
            2: return 7'b1011011;  // a b d e g
            3: return 7'b1001111;  // a b c d g
            4: return 7'b1100110;  // b c f g
            5: return 7'b1101101;  // a c d f g
            6: return 7'b1111101;  // a c d e f g
            7: return 7'b0000111;  // a b c
            8: return 7'b1111111;
            9: return 7'b1101111;  // a b c d f g
            default: return 7'b0;
        endcase
    endfunction

    function automatic logic [7:0] model_mask(input int d);
        int p = 1;
        if (m_show) return m_shadow[8*d +: 8];
        if (m_blink >= 0) return (m_blink % 2 == 0) ? 8'h80 : 8'h00;
        for (int k = 0; k < d; k++) p = p * 10;
        return {1'b0, digit_segs((m_value / p) % 10)};
    endfunction

    function automatic void seg_rect(input int s, output int x0, output int y0,
                                     output int w, output int h);
        case (s)
            0:       begin x0 = SW;     y0 = 0;           w = SL; h = SW; end
            1:       begin x0 = W - SW; y0 = SW;          w = SW; h = SL; end
            2:       begin x0 = W - SW; y0 = SL + 2 * SW; w = SW; h = SL; end
            3:       begin x0 = SW;     y0 = H - SW;      w = SL; h = SW; end
            4:       begin x0 = 0;      y0 = SL + 2 * SW; w = SW; h = SL; end
            5:       begin x0 = 0;      y0 = SW;          w = SW; h = SL; end
            6:       begin x0 = SW;     y0 = SL + SW;     w = SL; h = SW; end
            default: begin x0 = W + 2;  y0 = H - SW;      w = SW; h = SW; end
        endcase
    endfunction

    function automatic bit seg_hit(input int s, input int dx, input int dy);
        int x0, y0, w, h;
        seg_rect(s, x0, y0, w, h);
        if (!(dx >= x0 && dx < x0 + w && dy >= y0 && dy < y0 + h)) return 0;
`ifdef SEG7_BEVEL_EN
        if (s != 7) begin
            bit horiz;
            int u, v, a;
            horiz = (s == 0 || s == 3 || s == 6);
            u = horiz ? dx - x0 : dy - y0;
            v = horiz ? dy - y0 : dx - x0;
            a = (v >= SW / 2) ? v - SW / 2 : SW / 2 - v;
            return (u >= a) && (SL - 1 - u >= a);
        end
`endif
        return 1;
    endfunction

    function automatic logic [5:0] model_rgb(input int h, input int v, input logic on,
                                             input logic [5:0] bg);
        if (!on) return 6'b0;
        for (int d = 0; d < DIGITS; d++) begin
            logic [7:0] m = model_mask(d);
            for (int s = 0; s < 8; s++)
                if (m[s] && seg_hit(s, h - (OX + (DIGITS - 1 - d) * PITCH), v - OY))
                    return CYAN_C;
        end
        return bg;
    endfunction

    function automatic void model_step();
        if (m_blink < 0) begin
            if (m_value == 0) m_blink = 0;
            else m_value = m_value - 1;
        end else if (m_blink == 5) begin
            m_blink = -1;
            m_value = MAXV;
        end else begin
            m_blink = m_blink + 1;
        end
    endfunction

    function automatic void model_reset();
        m_value = MAXV; m_blink = -1; m_frames = 0; m_show = 0; m_shadow = '0;
    endfunction

    function automatic logic [5:0] rand_bg();
        logic [5:0] b = 6'($urandom);
        if (b == CYAN_C) b = 6'h15;
        return b;
    endfunction

    // segment centre in screen coordinates
    function automatic void seg_centre(input int d, input int s, output int px, output int py);
        int x0, y0, w, h;
        seg_rect(s, x0, y0, w, h);
        px = OX + (DIGITS - 1 - d) * PITCH + x0 + w / 2;
        py = OY + y0 + h / 2;
    endfunction

    // ---------------------------------------------------------------- stimulus helpers
    task automatic tick(input logic [15:0] u);
        @(negedge clk);
        frame_tick = 1'b1;
        user_seg   = u;
        @(negedge clk);
        frame_tick = 1'b0;
        if (!m_show) begin
            m_frames++;
            if (m_frames == FPS) begin
                m_frames = 0;
                model_step();
            end
        end
        m_show   = m_show || (u != 16'h0);
        m_shadow = u;
    endtask

    task automatic step_once();
        repeat (FPS) tick(16'h0);
    endtask

    task automatic get_pixel(input int h, input int v, input logic [5:0] bg,
                             output logic [5:0] got);
        @(negedge clk);
        hpos = 10'(h); vpos = 10'(v); display_on = 1'b1; bg_rgb = bg;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        got = rgb;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [5:0] got, exp, bg;
        int px, py;
        // drive activity during reset; frame_tick with user data must be ignored
        rst_n = 1'b0; display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        bg_rgb = 6'h2a; frame_tick = 1'b1; user_seg = 16'hffff;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++; if (rgb !== 6'b0) begin $display("FAIL reset_rgb: got %b expected 0", rgb); tests_failed++; end
        tests_run++; if (hsync_out !== 1'b0) begin $display("FAIL reset_hsync: got %b expected 0", hsync_out); tests_failed++; end
        tests_run++; if (vsync_out !== 1'b0) begin $display("FAIL reset_vsync: got %b expected 0", vsync_out); tests_failed++; end
        tests_run++; if (show !== 1'b0) begin $display("FAIL reset_show: got %b expected 0", show); tests_failed++; end
        frame_tick = 1'b0; user_seg = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        tests_run++; if (show !== 1'b0) begin $display("FAIL reset_show_after: got %b expected 0", show); tests_failed++; end
        for (int d = 0; d < DIGITS; d++)
            for (int s = 0; s < 8; s++) begin
                seg_centre(d, s, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                exp = model_rgb(px, py, 1'b1, bg);
                tests_run++;
                if (got !== exp) begin
                    $display("FAIL reset_99 d%0d s%0d: got %b expected %b", d, s, got, exp);
                    tests_failed++;
                end
            end
    endtask

    task automatic test_countdown();
        logic [5:0] got, exp, bg;
        int px, py;
        repeat (FPS - 1) tick(16'h0);
        // segment e of digit 0: off for 9, on for 8
        seg_centre(0, 4, px, py);
        bg = rand_bg();
        get_pixel(px, py, bg, got);
        tests_run++;
        if (got !== bg) begin $display("FAIL count_hold_99: got %b expected %b", got, bg); tests_failed++; end
        tick(16'h0);
        get_pixel(px, py, bg, got);
        tests_run++;
        if (got !== CYAN_C) begin $display("FAIL count_98_e: got %b expected %b", got, CYAN_C); tests_failed++; end
        for (int d = 0; d < DIGITS; d++)
            for (int s = 0; s < 8; s++) begin
                seg_centre(d, s, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                exp = model_rgb(px, py, 1'b1, bg);
                tests_run++;
                if (got !== exp) begin
                    $display("FAIL count_98 d%0d s%0d: got %b expected %b", d, s, got, exp);
                    tests_failed++;
                end
            end
    endtask

    task automatic test_pipeline();
        localparam int N = 160;
        logic [9:0] hh [N];
        logic [9:0] vv [N];
        logic       on [N];
        logic       hs [N];
        logic       vs [N];
        logic [5:0] bb [N];
        logic [5:0] exp;
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                exp = model_rgb(int'(hh[k-2]), int'(vv[k-2]), on[k-2], bb[k-2]);
                tests_run++;
                if (rgb !== exp) begin
                    $display("FAIL pipe_rgb k%0d: got %b expected %b", k, rgb, exp);
                    tests_failed++;
                end
                tests_run++;
                if (hsync_out !== hs[k-2]) begin
                    $display("FAIL pipe_hsync k%0d: got %b expected %b", k, hsync_out, hs[k-2]);
                    tests_failed++;
                end
                tests_run++;
                if (vsync_out !== vs[k-2]) begin
                    $display("FAIL pipe_vsync k%0d: got %b expected %b", k, vsync_out, vs[k-2]);
                    tests_failed++;
                end
            end
            if (k < N) begin
                hh[k] = 10'($urandom_range(180, 340));
                vv[k] = 10'($urandom_range(150, 260));
                on[k] = ($urandom_range(0, 3) != 0);
                hs[k] = 1'($urandom);
                vs[k] = 1'($urandom);
                bb[k] = rand_bg();
                hpos = hh[k]; vpos = vv[k]; display_on = on[k];
                hsync_in = hs[k]; vsync_in = vs[k]; bg_rgb = bb[k];
            end
        end
        hsync_in = 1'b0; vsync_in = 1'b0;
    endtask

    task automatic test_bevel();
        logic [5:0] got, bg;
        int x0 = OX + PITCH;  // digit 0 cell, showing 8 (segment a lit)
        bg = rand_bg();
        get_pixel(x0 + SW, OY, bg, got);
`ifdef SEG7_BEVEL_EN
        tests_run++;
        if (got !== bg) begin $display("FAIL bevel_corner: got %b expected %b", got, bg); tests_failed++; end
`else
        tests_run++;
        if (got !== CYAN_C) begin $display("FAIL bevel_corner: got %b expected %b", got, CYAN_C); tests_failed++; end
`endif
        get_pixel(x0 + SW + SL / 2, OY + SW / 2, bg, got);
        tests_run++;
        if (got !== CYAN_C) begin $display("FAIL bevel_mid: got %b expected %b", got, CYAN_C); tests_failed++; end
    endtask

    task automatic test_borrow();
        logic [5:0] got, exp, bg;
        int px, py, x0, y0, w, h, d, s;
        for (int n = 0; n < 20 && m_value != 90; n++) step_once();
        for (int pass = 0; pass < 92; pass++) begin
            if (m_value == 90 || m_value == 89 || m_value == 0) begin
                for (int dd = 0; dd < DIGITS; dd++)
                    for (int ss = 0; ss < 8; ss++) begin
                        seg_centre(dd, ss, px, py);
                        bg = rand_bg();
                        get_pixel(px, py, bg, got);
                        exp = model_rgb(px, py, 1'b1, bg);
                        tests_run++;
                        if (got !== exp) begin
                            $display("FAIL borrow_v%0d d%0d s%0d: got %b expected %b",
                                     m_value, dd, ss, got, exp);
                            tests_failed++;
                        end
                    end
            end else begin
                d = $urandom_range(0, DIGITS - 1);
                s = $urandom_range(0, 7);
                seg_rect(s, x0, y0, w, h);
                px = OX + (DIGITS - 1 - d) * PITCH + x0 + $urandom_range(0, w - 1);
                py = OY + y0 + $urandom_range(0, h - 1);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                exp = model_rgb(px, py, 1'b1, bg);
                tests_run++;
                if (got !== exp) begin
                    $display("FAIL borrow_rand v%0d (%0d,%0d): got %b expected %b",
                             m_value, px, py, got, exp);
                    tests_failed++;
                end
            end
            if (m_blink < 0) step_once();
        end
    endtask

    task automatic test_blink();
        logic [5:0] got, bg;
        int px, py;
        for (int b = 0; b < 6; b++) begin
            for (int d = 0; d < DIGITS; d++) begin
                seg_centre(d, 7, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                tests_run++;
                if (got !== ((b % 2 == 0) ? CYAN_C : bg)) begin
                    $display("FAIL blink_dp b%0d d%0d: got %b expected %b", b, d, got,
                             (b % 2 == 0) ? CYAN_C : bg);
                    tests_failed++;
                end
                seg_centre(d, 0, px, py);
                get_pixel(px, py, bg, got);
                tests_run++;
                if (got !== bg) begin
                    $display("FAIL blink_a b%0d d%0d: got %b expected %b", b, d, got, bg);
                    tests_failed++;
                end
            end
            step_once();
        end
        for (int d = 0; d < DIGITS; d++)
            for (int s = 0; s < 8; s++) begin
                seg_centre(d, s, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                tests_run++;
                // reloaded 99: every segment except e and dp lit
                if (got !== ((s == 4 || s == 7) ? bg : CYAN_C)) begin
                    $display("FAIL blink_reload d%0d s%0d: got %b expected %b", d, s, got,
                             (s == 4 || s == 7) ? bg : CYAN_C);
                    tests_failed++;
                end
            end
    endtask

    task automatic test_user_mode();
        logic [5:0]  got, exp, bg;
        logic [15:0] u;
        int px, py, d, s, x0, y0, w, h;
        repeat (FPS - 1) tick(16'h0);  // step and show rise together on the next tick
        tick(16'h0006);
        tests_run++;
        if (show !== 1'b1) begin $display("FAIL user_show: got %b expected 1", show); tests_failed++; end
        for (int dd = 0; dd < DIGITS; dd++)
            for (int ss = 0; ss < 8; ss++) begin
                seg_centre(dd, ss, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                tests_run++;
                if (got !== ((dd == 0 && (ss == 1 || ss == 2)) ? CYAN_C : bg)) begin
                    $display("FAIL user_0006 d%0d s%0d: got %b expected %b", dd, ss, got,
                             (dd == 0 && (ss == 1 || ss == 2)) ? CYAN_C : bg);
                    tests_failed++;
                end
            end
        tick(16'h0);
        tests_run++;
        if (show !== 1'b1) begin $display("FAIL user_sticky: got %b expected 1", show); tests_failed++; end
        for (int dd = 0; dd < DIGITS; dd++)
            for (int ss = 0; ss < 8; ss++) begin
                seg_centre(dd, ss, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                tests_run++;
                if (got !== bg) begin
                    $display("FAIL user_blank d%0d s%0d: got %b expected %b", dd, ss, got, bg);
                    tests_failed++;
                end
            end
        for (int r = 0; r < 6; r++) begin
            u = 16'($urandom);
            tick(u);
            for (int p = 0; p < 6; p++) begin
                d = $urandom_range(0, DIGITS - 1);
                s = $urandom_range(0, 7);
                seg_rect(s, x0, y0, w, h);
                px = OX + (DIGITS - 1 - d) * PITCH + x0 + $urandom_range(0, w - 1);
                py = OY + y0 + $urandom_range(0, h - 1);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                exp = model_rgb(px, py, 1'b1, bg);
                tests_run++;
                if (got !== exp) begin
                    $display("FAIL user_rand u%h (%0d,%0d): got %b expected %b", u, px, py, got, exp);
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [5:0] got, exp, bg;
        int px, py;
        seg_centre(0, 1, px, py);
        @(negedge clk);
        hpos = 10'(px); vpos = 10'(py); display_on = 1'b1; bg_rgb = 6'h3f;
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++; if (rgb !== 6'b0) begin $display("FAIL midrst_rgb: got %b expected 0", rgb); tests_failed++; end
        tests_run++; if (hsync_out !== 1'b0) begin $display("FAIL midrst_hsync: got %b expected 0", hsync_out); tests_failed++; end
        tests_run++; if (vsync_out !== 1'b0) begin $display("FAIL midrst_vsync: got %b expected 0", vsync_out); tests_failed++; end
        tests_run++; if (show !== 1'b0) begin $display("FAIL midrst_show: got %b expected 0", show); tests_failed++; end
        hsync_in = 1'b0; vsync_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < DIGITS; d++)
            for (int s = 0; s < 8; s++) begin
                seg_centre(d, s, px, py);
                bg = rand_bg();
                get_pixel(px, py, bg, got);
                exp = model_rgb(px, py, 1'b1, bg);
                tests_run++;
                if (got !== exp) begin
                    $display("FAIL midrst_99 d%0d s%0d: got %b expected %b", d, s, got, exp);
                    tests_failed++;
                end
            end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pipeline();
        test_bevel();
        test_borrow();
        test_blink();
        test_user_mode();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
